// File: rtl/adxl345_poll_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adxl345_poll_sequencer: periodic/one-shot X/Y/Z burst-read command engine    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module adxl345_poll_sequencer #(
    parameter logic [31:0] DEFAULT_REQUEST_INTERVAL = 32'd10000,
    parameter logic [7:0]  DEFAULT_I2C_ADDRESS      = 8'hA6,
    parameter int          TIMEOUT_CYCLES           = 100000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        single_request,
    input  logic [31:0] request_interval,
    input  logic [7:0]  i2c_address,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [15:0] data_x,
    output logic [15:0] data_y,
    output logic [15:0] data_z,
    output logic        data_valid,
    output logic        busy,
    output logic        error,
    output logic [31:0] poll_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_WADDR = 3'd1,
        S_TX_REG   = 3'd2,
        S_TX_RADDR = 3'd3,
        S_TX_LEN   = 3'd4,
        S_RX_DATA  = 3'd5,
        S_PUBLISH  = 3'd6
    } state_t;

    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [31:0]     r_timer;
    logic [31:0]     r_timeout;
    logic            r_pending;
    logic            r_pending_sw;
    logic [6:0]      r_addr7;
    logic [2:0]      r_idx;
    logic [4:0][7:0] r_buf;

    logic [31:0]     w_intv;
    logic [6:0]      w_addr7;
    logic            w_tick;
    logic            w_take;

    assign w_intv  = (request_interval == 32'd0) ? DEFAULT_REQUEST_INTERVAL : request_interval;
    assign w_addr7 = (i2c_address == 8'd0) ? DEFAULT_I2C_ADDRESS[7:1] : i2c_address[7:1];
    // >= rather than == so a shrinking interval fires on the next cycle
    assign w_tick  = enable && (r_timer >= (w_intv - 32'd1));
    assign w_take  = (r_state == S_IDLE) && r_pending;

    // A software request survives enable=0; a timer-sourced request does not.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_timer      <= 32'd0;
            r_pending    <= 1'b0;
            r_pending_sw <= 1'b0;
        end else begin
            if (!enable || w_tick)
                r_timer <= 32'd0;
            else
                r_timer <= r_timer + 32'd1;

            if (single_request)
                r_pending_sw <= 1'b1;
            else if (w_take)
                r_pending_sw <= 1'b0;

            if (w_tick || single_request)
                r_pending <= 1'b1;
            else if (w_take)
                r_pending <= 1'b0;
            else if (!enable && !r_pending_sw)
                r_pending <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_timeout     <= 32'd0;
            r_addr7       <= 7'd0;
            r_idx         <= 3'd0;
            r_buf         <= '0;
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b0;
            data_x        <= 16'd0;
            data_y        <= 16'd0;
            data_z        <= 16'd0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            poll_count    <= 32'd0;
        end else begin
            s_axis_tready <= 1'b1;
            data_valid    <= 1'b0;
            error         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_addr7       <= w_addr7;
                        m_axis_tdata  <= {w_addr7, 1'b0};
                        m_axis_tlast  <= 1'b0;
                        m_axis_tvalid <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= S_TX_WADDR;
                    end
                end
                S_TX_WADDR: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= 8'h32;
                        m_axis_tlast <= 1'b1;
                        r_state      <= S_TX_REG;
                    end
                end
                S_TX_REG: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= {r_addr7, 1'b1};
                        m_axis_tlast <= 1'b0;
                        r_state      <= S_TX_RADDR;
                    end
                end
                S_TX_RADDR: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= 8'd6;
                        m_axis_tlast <= 1'b1;
                        r_state      <= S_TX_LEN;
                    end
                end
                S_TX_LEN: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= 8'd0;
                        r_idx         <= 3'd0;
                        r_timeout     <= 32'd0;
                        r_state       <= S_RX_DATA;
                    end
                end
                S_RX_DATA: begin
                    r_timeout <= r_timeout + 32'd1;
                    if (s_axis_tvalid) begin
                        if (r_idx == 3'd5) begin
                            if (s_axis_tlast) begin
                                // publish straight from the final byte to save a cycle
                                data_x     <= {r_buf[1], r_buf[0]};
                                data_y     <= {r_buf[3], r_buf[2]};
                                data_z     <= {s_axis_tdata, r_buf[4]};
                                data_valid <= 1'b1;
                                poll_count <= poll_count + 32'd1;
                                r_state    <= S_PUBLISH;
                            end else begin
                                error   <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else if (s_axis_tlast) begin
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_buf[r_idx] <= s_axis_tdata;
                            r_idx        <= r_idx + 3'd1;
                        end
                    end else if (r_timeout == c_timeout_last) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_PUBLISH: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adxl345_poll_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adxl345_poll_sequencer: randomized transaction-level bench with model    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_adxl345_poll_sequencer;

    localparam int c_def_intv = 400;
    localparam int c_timeout  = 200;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        single_request = 1'b0;
    logic [31:0] request_interval = 32'd0;
    logic [7:0]  i2c_address = 8'd0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [15:0] data_x, data_y, data_z;
    logic        data_valid, busy, error;
    logic [31:0] poll_count;

    always #5 aclk = ~aclk;

    adxl345_poll_sequencer #(
        .DEFAULT_REQUEST_INTERVAL(32'(c_def_intv)),
        .DEFAULT_I2C_ADDRESS     (8'hA6),
        .TIMEOUT_CYCLES          (c_timeout)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .enable          (enable),
        .single_request  (single_request),
        .request_interval(request_interval),
        .i2c_address     (i2c_address),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .data_x          (data_x),
        .data_y          (data_y),
        .data_z          (data_z),
        .data_valid      (data_valid),
        .busy            (busy),
        .error           (error),
        .poll_count      (poll_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: one poll = 4 command words then a response whose
    // shape is chosen by resp_mode (0 good, 1 early tlast, 2 no tlast, 3 silent, 4 partial).
    logic [8:0]  cmd_q[$];
    logic [8:0]  resp_q[$];
    int          resp_mode = 0;
    int          err_idx = 2;
    bit          bp_on = 0, gaps_on = 0, req_now = 0;
    bit          pub_due = 0, err_due = 0, tmo_due = 0, busy_chk = 0;
    bit          stall_prev = 0;
    logic [9:0]  stall_word = '0;
    logic [15:0] last_x = 0, last_y = 0, last_z = 0, nx = 0, ny = 0, nz = 0;
    int          exp_pubs = 0, n_valid = 0, n_err = 0, loads = 0;
    int          cyc = 0, cmd_done_cyc = 0, last_byte_cyc = 0;

    task automatic load_response();
        logic [7:0] b[6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        loads++;
        case (resp_mode)
            0: begin
                for (int i = 0; i < 6; i++) resp_q.push_back({1'(i == 5), b[i]});
                nx = {b[1], b[0]};
                ny = {b[3], b[2]};
                nz = {b[5], b[4]};
                pub_due  = 1;
                busy_chk = 1;
            end
            1: begin
                for (int i = 0; i <= err_idx; i++) resp_q.push_back({1'(i == err_idx), b[i]});
                err_due = 1;
            end
            2: begin
                for (int i = 0; i < 6; i++) resp_q.push_back({1'b0, b[i]});
                err_due = 1;
            end
            3: begin
                err_due = 1;
                tmo_due = 1;
            end
            default: for (int i = 0; i < 3; i++) resp_q.push_back({1'b0, b[i]});
        endcase
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs and
    // log the handshakes that will complete on the next rising edge.
    task automatic cycle();
        logic [7:0] eff;
        @(negedge aclk);
        cyc++;
        if (stall_prev)
            check_eq("tdata_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, stall_word);
        if (data_valid) begin
            n_valid++;
            check_eq("pub_expected", pub_due, 1);
            check_eq("pub_latency", cyc - last_byte_cyc, 1);
            check_eq("data_x", data_x, nx);
            check_eq("data_y", data_y, ny);
            check_eq("data_z", data_z, nz);
            exp_pubs++;
            check_eq("poll_count", poll_count, exp_pubs);
            last_x = nx; last_y = ny; last_z = nz;
            pub_due = 0;
        end
        if (busy_chk && !pub_due && cyc == last_byte_cyc + 2) begin
            check_eq("busy_after_pub", busy, 0);
            busy_chk = 0;
        end
        if (error) begin
            n_err++;
            check_eq("err_expected", err_due, 1);
            if (tmo_due) check_eq("timeout_latency", cyc - cmd_done_cyc, c_timeout + 1);
            check_eq("err_keep_x", data_x, last_x);
            check_eq("err_keep_z", data_z, last_z);
            check_eq("err_keep_count", poll_count, exp_pubs);
            err_due = 0;
            tmo_due = 0;
        end

        single_request = req_now;
        req_now        = 0;
        m_axis_tready  = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
        if (resp_q.size() > 0 && (!gaps_on || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid = 1'b1;
            {s_axis_tlast, s_axis_tdata} = resp_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tdata  = 8'($urandom);
        end

        if (m_axis_tvalid && m_axis_tready) cmd_q.push_back({m_axis_tlast, m_axis_tdata});
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_word = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
        if (s_axis_tvalid && s_axis_tready) begin
            void'(resp_q.pop_front());
            last_byte_cyc = cyc;
        end
        if (cmd_q.size() == 4) begin
            eff = (i2c_address == 8'h00) ? 8'hA6 : i2c_address;
            check_eq("cmd_waddr", cmd_q[0], {1'b0, eff[7:1], 1'b0});
            check_eq("cmd_reg",   cmd_q[1], 9'h132);
            check_eq("cmd_raddr", cmd_q[2], {1'b0, eff[7:1], 1'b1});
            check_eq("cmd_len",   cmd_q[3], 9'h106);
            cmd_q.delete();
            cmd_done_cyc = cyc;
            load_response();
        end
    endtask

    task automatic wait_valid(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            cycle();
            if (data_valid) break;
        end
        if (k == limit) check_eq("valid_wait", data_valid, 1);
    endtask

    task automatic wait_idle(input int limit);
        int quiet = 0;
        int k;
        for (k = 0; k < limit && quiet < 20; k++) begin
            cycle();
            if (!busy && resp_q.size() == 0 && !pub_due && !err_due) quiet++;
            else quiet = 0;
        end
        if (quiet < 20) check_eq("idle_wait", busy, 0);
    endtask

    initial begin
        int t1, v0, e0, l0, k;

        repeat (3) cycle();
        check_eq("rst_flags", {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, data_valid, error}, 0);
        check_eq("rst_data_x", data_x, 0);
        check_eq("rst_data_z", data_z, 0);
        check_eq("rst_count", poll_count, 0);
        aresetn = 1'b1;
        cycle();
        check_eq("ready_after_rst", s_axis_tready, 1);

        // Default interval and address, periodic polling
        resp_mode = 0;
        enable    = 1'b1;
        wait_valid(1000);
        t1 = cyc;
        wait_valid(1000);
        check_eq("poll_period", cyc - t1, c_def_intv);
        enable = 1'b0;
        wait_idle(2000);

        // Command back-pressure with custom interval/address and gapped responses
        request_interval = 32'd50;
        i2c_address      = 8'h3A;
        bp_on   = 1;
        gaps_on = 1;
        v0      = n_valid;
        enable  = 1'b1;
        for (k = 0; k < 3000 && n_valid < v0 + 3; k++) cycle();
        check_eq("bp_polls", (n_valid >= v0 + 3) ? 3 : n_valid - v0, 3);
        enable = 1'b0;
        wait_idle(2000);
        bp_on = 0;

        // Early tlast on byte 2, then missing tlast on byte 5
        v0 = n_valid; e0 = n_err;
        resp_mode = 1; err_idx = 2; req_now = 1;
        wait_idle(2000);
        resp_mode = 2; req_now = 1;
        wait_idle(2000);
        check_eq("frame_errors", n_err - e0, 2);
        check_eq("frame_no_pub", n_valid - v0, 0);

        // Silent device: timeout
        e0 = n_err;
        resp_mode = 3; req_now = 1;
        wait_idle(2000);
        check_eq("timeout_errors", n_err - e0, 1);

        // One request, then two more while busy: merged into a single extra poll
        resp_mode = 0;
        v0 = n_valid;
        req_now = 1;
        for (k = 0; k < 50 && !busy; k++) cycle();
        repeat (2) cycle();
        req_now = 1;
        repeat (3) cycle();
        req_now = 1;
        wait_idle(2000);
        check_eq("sreq_polls", n_valid - v0, 2);

        // Asynchronous reset while a partial sample sits in RX_DATA
        resp_mode = 4;
        l0 = loads;
        req_now = 1;
        for (k = 0; k < 200 && !(loads > l0 && resp_q.size() == 0); k++) cycle();
        repeat (2) cycle();
        check_eq("pre_rst_busy", busy, 1);
        #2 aresetn = 1'b0;
        #1;
        check_eq("arst_flags", {m_axis_tvalid, s_axis_tready, busy, data_valid, error}, 0);
        check_eq("arst_data_x", data_x, 0);
        check_eq("arst_data_y", data_y, 0);
        check_eq("arst_count", poll_count, 0);
        exp_pubs = 0; last_x = 0; last_y = 0; last_z = 0;
        pub_due = 0; err_due = 0; tmo_due = 0; busy_chk = 0; stall_prev = 0;
        resp_q.delete();
        cmd_q.delete();
        repeat (3) cycle();
        aresetn = 1'b1;
        v0 = n_valid;
        repeat (60) cycle();
        check_eq("post_rst_no_pub", n_valid - v0, 0);
        check_eq("post_rst_count", poll_count, 0);
        check_eq("post_rst_data_z", data_z, 0);
        check_eq("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
